// File: rtl/spu_pkg.sv
// Shared SPU constants and types: datapath widths, instruction format codes,
// the issue bundle, the NOP bubble and the pending-write scoreboard entry.
// Optional feature macro: FWD_BYPASS_EN (writeback bypass, shorter scoreboard).
package spu_pkg;

    localparam int DATA_W     = 128;
    localparam int REG_ADDR_W = 7;
    localparam int OP_W       = 11;
    localparam int IMM_W      = 18;
    localparam int FMT_W      = 3;
    localparam int NUM_REGS   = 128;

    // Instruction format encodings carried alongside the opcode
    localparam logic [FMT_W-1:0] FMT_RR   = 3'd0;
    localparam logic [FMT_W-1:0] FMT_RRR  = 3'd1;
    localparam logic [FMT_W-1:0] FMT_RI7  = 3'd2;
    localparam logic [FMT_W-1:0] FMT_RI10 = 3'd3;
    localparam logic [FMT_W-1:0] FMT_RI16 = 3'd4;
    localparam logic [FMT_W-1:0] FMT_RI18 = 3'd5;

    // With the bypass, a consumer may issue in the producer's writeback
    // cycle, so one fewer in-flight slot needs tracking.
`ifdef FWD_BYPASS_EN
    localparam int SB_DEPTH = 2;
`else
    localparam int SB_DEPTH = 3;
`endif

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [FMT_W-1:0]      format;
        logic [IMM_W-1:0]      imm;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic                  reg_write;
        logic [DATA_W-1:0]     ra;
        logic [DATA_W-1:0]     rb;
    } issue_t;

    // Bubble: everything zero, never writes a register
    localparam issue_t NOP_ISSUE = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
    } sb_entry_t;

    // True when a scoreboard entry holds a pending write to the given register
    function automatic logic sb_hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] a);
        return e.valid && (e.addr == a);
    endfunction

endpackage

// File: rtl/reg_fetch_if.sv
// Bundle between decode, register fetch and execute.
// Handshake: decode holds dec_valid and the instruction fields stable; the
// instruction is taken in any cycle where dec_valid=1 and dec_ready=1 and
// shows up on the issue outputs one cycle later. dec_ready is combinational
// and may drop while dec_valid=1 (RAW hazard); decode must then keep
// presenting the same instruction. Issue outputs have no ready: execute
// always consumes them, a bubble is an all-zero bundle. Writeback is a
// plain write strobe (reg_write_wb) with address and data.
// sb_valid_dbg exposes the valid bits of the pending-write scoreboard.
interface reg_fetch_if;
    import spu_pkg::*;

    // decode -> fetch
    logic                  dec_valid;
    logic [OP_W-1:0]       op_in;
    logic [FMT_W-1:0]      format_in;
    logic [IMM_W-1:0]      imm_in;
    logic [REG_ADDR_W-1:0] ra_addr;
    logic [REG_ADDR_W-1:0] rb_addr;
    logic [REG_ADDR_W-1:0] rt_addr_in;
    logic                  reg_write_in;
    logic                  dec_ready;

    // fetch -> execute
    logic [OP_W-1:0]       op;
    logic [FMT_W-1:0]      format;
    logic [IMM_W-1:0]      imm;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic                  reg_write;
    logic [DATA_W-1:0]     ra;
    logic [DATA_W-1:0]     rb;

    // execute -> fetch writeback
    logic [DATA_W-1:0]     rt_wb;
    logic [REG_ADDR_W-1:0] rt_addr_wb;
    logic                  reg_write_wb;

    // scoreboard observation
    logic [SB_DEPTH-1:0]   sb_valid_dbg;

    modport slave (
        input  dec_valid, op_in, format_in, imm_in, ra_addr, rb_addr,
               rt_addr_in, reg_write_in, rt_wb, rt_addr_wb, reg_write_wb,
        output dec_ready, op, format, imm, rt_addr, reg_write, ra, rb,
               sb_valid_dbg
    );

    modport master (
        output dec_valid, op_in, format_in, imm_in, ra_addr, rb_addr,
               rt_addr_in, reg_write_in, rt_wb, rt_addr_wb, reg_write_wb,
        input  dec_ready, op, format, imm, rt_addr, reg_write, ra, rb,
               sb_valid_dbg
    );

endinterface

// File: rtl/reg_fetch_reg_file.sv
// 128 x 128-bit register file: two combinational read ports, one write port
// committed at the rising edge. Reads return array contents only; any
// same-cycle forwarding is done by the caller.
module reg_file
    import spu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0]     ra_data,
    output logic [DATA_W-1:0]     rb_data,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0]     wd
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    // Next array contents: unchanged except the written entry
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wa] = wd;
        end
    end

    // Array storage; reset clears every register, r0 included
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/reg_fetch.sv
// Register fetch stage: reads two sources, stalls on read-after-write
// hazards against recently issued producers, and registers the issue bundle
// for the execute unit (1-cycle latency).
// Optional feature macro: FWD_BYPASS_EN -- forwards same-cycle writeback data
// to the read ports and shortens the scoreboard from 3 to 2 entries.
module reg_fetch
    import spu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    reg_fetch_if.slave  bus
);

    sb_entry_t         sb_q [SB_DEPTH];
    sb_entry_t         sb_d [SB_DEPTH];
    issue_t            issue_q;
    issue_t            issue_d;

    logic              src_hit;
    logic              hazard;
    logic              accept;
    logic              wb_en;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] ra_val;
    logic [DATA_W-1:0] rb_val;

    // Writeback is ignored while reset is held
    assign wb_en = bus.reg_write_wb && !reset;

    reg_file u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (bus.ra_addr),
        .rb_addr (bus.rb_addr),
        .ra_data (rd_a),
        .rb_data (rd_b),
        .we      (wb_en),
        .wa      (bus.rt_addr_wb),
        .wd      (bus.rt_wb)
    );

    // Hazard: either source matches any pending write, used by the format or not
    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_hit(sb_q[i], bus.ra_addr) || sb_hit(sb_q[i], bus.rb_addr)) begin
                src_hit = 1'b1;
            end
        end
        hazard = bus.dec_valid && !reset && src_hit;
        accept = bus.dec_valid && !reset && !src_hit;
    end

    assign bus.dec_ready = !hazard;

    // Source operand select: array value, optionally overridden by writeback
    always_comb begin
        ra_val = rd_a;
        rb_val = rd_b;
`ifdef FWD_BYPASS_EN
        if (wb_en && (bus.rt_addr_wb == bus.ra_addr)) begin
            ra_val = bus.rt_wb;
        end
        if (wb_en && (bus.rt_addr_wb == bus.rb_addr)) begin
            rb_val = bus.rt_wb;
        end
`endif
    end

    // Next issue bundle and scoreboard shift; bubbles enter as invalid slots
    always_comb begin
        issue_d = NOP_ISSUE;
        if (accept) begin
            issue_d.op        = bus.op_in;
            issue_d.format    = bus.format_in;
            issue_d.imm       = bus.imm_in;
            issue_d.rt_addr   = bus.rt_addr_in;
            issue_d.reg_write = bus.reg_write_in;
            issue_d.ra        = ra_val;
            issue_d.rb        = rb_val;
        end
        sb_d[0].valid = accept && bus.reg_write_in;
        sb_d[0].addr  = accept ? bus.rt_addr_in : '0;
        for (int i = 1; i < SB_DEPTH; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    // Issue register and scoreboard state; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q <= NOP_ISSUE;
            sb_q    <= '{default: '0};
        end else begin
            issue_q <= issue_d;
            sb_q    <= sb_d;
        end
    end

    // Scoreboard valid bits for observation
    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            bus.sb_valid_dbg[i] = sb_q[i].valid;
        end
    end

    assign bus.op        = issue_q.op;
    assign bus.format    = issue_q.format;
    assign bus.imm       = issue_q.imm;
    assign bus.rt_addr   = issue_q.rt_addr;
    assign bus.reg_write = issue_q.reg_write;
    assign bus.ra        = issue_q.ra;
    assign bus.rb        = issue_q.rb;

endmodule
